// File: rtl/multdiv_ctrl_if.sv
// rtl/multdiv_ctrl_if.sv - pipeline <-> multdiv controller signal bundle
interface multdiv_ctrl_if;
  logic        dx_is_md;
  logic        dx_is_div;
  logic [4:0]  dx_rd;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        md_ready;
  logic        md_exception;
  logic [31:0] md_result;
  logic        stall;
  logic        bubble;
  logic        mw_wen;
  logic [4:0]  mw_rd;
  logic [31:0] mw_data;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  // Pipeline / multdiv unit side
  modport master (
    output dx_is_md, dx_is_div, dx_rd, md_ready, md_exception, md_result,
           mw_wen, mw_rd, mw_data,
    input  ctrl_mult, ctrl_div, stall, bubble, wb_en, wb_reg, wb_data
  );

  // Controller side
  modport slave (
    input  dx_is_md, dx_is_div, dx_rd, md_ready, md_exception, md_result,
           mw_wen, mw_rd, mw_data,
    output ctrl_mult, ctrl_div, stall, bubble, wb_en, wb_reg, wb_data
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - issue/stall/writeback controller for an iterative mult/div unit
module multdiv_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic          clock,
  input  logic          reset,
  multdiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, WB} state_e;

  localparam logic [5:0]  TMO      = 6'(TIMEOUT);
  localparam logic [4:0]  EXC_REG  = 5'd30;
  localparam logic [31:0] EXC_MULT = 32'd4;
  localparam logic [31:0] EXC_DIV  = 32'd5;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic        div_q, div_d;
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      rd_q    <= 5'd0;
      div_q   <= 1'b0;
      res_q   <= 32'd0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      div_q   <= div_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    div_d   = div_q;
    res_d   = res_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE: begin
        if (bus.dx_is_md) begin
          state_d = ISSUE;
          rd_d    = bus.dx_rd;
          div_d   = bus.dx_is_div;
        end
      end
      ISSUE: begin
        cnt_d   = 6'd0;
        state_d = BUSY;
      end
      BUSY: begin
        // A real completion wins even on the timeout cycle
        if (bus.md_ready) begin
          res_d   = bus.md_result;
          exc_d   = bus.md_exception;
          state_d = WB;
        end else if (cnt_q == TMO) begin
          exc_d   = 1'b1;
          state_d = WB;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      WB: begin
        if (!bus.mw_wen) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic        grant;
  logic        sel_wen;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;

  always_comb begin
    grant         = (state_q == WB) && !bus.mw_wen;
    bus.ctrl_mult = (state_q == ISSUE) && !div_q;
    bus.ctrl_div  = (state_q == ISSUE) && div_q;
    bus.bubble    = (state_q != IDLE) || bus.dx_is_md;
    // Held in reset the pipeline must never be frozen
    bus.stall     = reset && bus.bubble && !grant;

    sel_wen  = bus.mw_wen;
    sel_reg  = bus.mw_rd;
    sel_data = bus.mw_data;
    if (grant) begin
      sel_wen  = 1'b1;
      sel_reg  = exc_q ? EXC_REG : rd_q;
      sel_data = exc_q ? (div_q ? EXC_DIV : EXC_MULT) : res_q;
    end
    bus.wb_en   = sel_wen && (sel_reg != 5'd0);
    bus.wb_reg  = sel_reg;
    bus.wb_data = sel_data;
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - directed self-checking bench for multdiv_ctrl
module tb_multdiv_ctrl;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  multdiv_ctrl_if bus ();

  multdiv_ctrl #(.TIMEOUT(40)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic quiet_inputs;
    bus.dx_is_md     = 1'b0;
    bus.dx_is_div    = 1'b0;
    bus.dx_rd        = 5'd0;
    bus.md_ready     = 1'b0;
    bus.md_exception = 1'b0;
    bus.md_result    = 32'd0;
    bus.mw_wen       = 1'b0;
    bus.mw_rd        = 5'd0;
    bus.mw_data      = 32'd0;
  endtask

  task automatic test_reset;
    quiet_inputs();
    reset       = 1'b0;
    bus.mw_wen  = 1'b1;
    bus.mw_rd   = 5'd9;
    bus.mw_data = 32'h0000_1234;
    #4;
    if (bus.stall !== 1'b0) begin $display("FAIL rst_stall: got %b want 0", bus.stall); n_err++; end
    n_vec++;
    if (bus.bubble !== 1'b0) begin $display("FAIL rst_bubble: got %b want 0", bus.bubble); n_err++; end
    n_vec++;
    if ({bus.ctrl_mult, bus.ctrl_div} !== 2'b00) begin $display("FAIL rst_ctrl: got %b want 00", {bus.ctrl_mult, bus.ctrl_div}); n_err++; end
    n_vec++;
    if ({bus.wb_en, bus.wb_reg, bus.wb_data} !== {1'b1, 5'd9, 32'h0000_1234}) begin
      $display("FAIL rst_passthru: got %b/%0d/%h want 1/9/00001234", bus.wb_en, bus.wb_reg, bus.wb_data); n_err++;
    end
    n_vec++;
    bus.dx_is_md = 1'b1;
    tick();
    #4;
    if (bus.stall !== 1'b0) begin $display("FAIL rst_stall_md: got %b want 0", bus.stall); n_err++; end
    n_vec++;
    if (bus.ctrl_mult !== 1'b0) begin $display("FAIL rst_no_issue: got %b want 0", bus.ctrl_mult); n_err++; end
    n_vec++;
    quiet_inputs();
    tick();
    reset = 1'b1;
    tick();
    bus.mw_wen  = 1'b1;
    bus.mw_rd   = 5'd0;
    bus.mw_data = 32'hFFFF_FFFF;
    #4;
    if (bus.wb_en !== 1'b0) begin $display("FAIL idle_r0_wen: got %b want 0", bus.wb_en); n_err++; end
    n_vec++;
    if (bus.stall !== 1'b0) begin $display("FAIL idle_stall: got %b want 0", bus.stall); n_err++; end
    n_vec++;
    quiet_inputs();
    tick();
  endtask

  task automatic test_mult_basic;
    bus.dx_is_md  = 1'b1;
    bus.dx_is_div = 1'b0;
    bus.dx_rd     = 5'd5;
    #4;
    if ({bus.bubble, bus.stall, bus.ctrl_mult} !== 3'b110) begin
      $display("FAIL mult_detect: got bubble/stall/mult %b want 110", {bus.bubble, bus.stall, bus.ctrl_mult}); n_err++;
    end
    n_vec++;
    tick(); #4;
    if ({bus.ctrl_mult, bus.ctrl_div, bus.stall} !== 3'b101) begin
      $display("FAIL mult_issue: got mult/div/stall %b want 101", {bus.ctrl_mult, bus.ctrl_div, bus.stall}); n_err++;
    end
    n_vec++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin
        bus.md_ready  = 1'b1;
        bus.md_result = 32'h0000_0042;
      end
      #4;
      if ({bus.ctrl_mult, bus.ctrl_div, bus.stall, bus.wb_en} !== 4'b0010) begin
        $display("FAIL mult_busy%0d: got mult/div/stall/wen %b want 0010", i, {bus.ctrl_mult, bus.ctrl_div, bus.stall, bus.wb_en}); n_err++;
      end
      n_vec++;
    end
    tick();
    bus.md_ready  = 1'b0;
    bus.md_result = 32'h0;
    #4;
    if ({bus.wb_en, bus.wb_reg, bus.wb_data, bus.stall, bus.bubble} !== {1'b1, 5'd5, 32'h42, 1'b0, 1'b1}) begin
      $display("FAIL mult_wb: got wen/reg/data/stall/bubble %b/%0d/%h/%b/%b want 1/5/00000042/0/1",
               bus.wb_en, bus.wb_reg, bus.wb_data, bus.stall, bus.bubble); n_err++;
    end
    n_vec++;
    tick();
    bus.dx_is_md = 1'b0;
    #4;
    if ({bus.ctrl_mult, bus.stall, bus.bubble, bus.wb_en} !== 4'b0000) begin
      $display("FAIL mult_release: got mult/stall/bubble/wen %b want 0000", {bus.ctrl_mult, bus.stall, bus.bubble, bus.wb_en}); n_err++;
    end
    n_vec++;
    tick(); #4;
    if (bus.ctrl_mult !== 1'b0) begin $display("FAIL mult_no_reissue: got %b want 0", bus.ctrl_mult); n_err++; end
    n_vec++;
    tick();
  endtask

  // Minimum-latency path with an exception, for div then mult
  task automatic test_exception;
    for (int k = 0; k < 2; k++) begin
      logic        is_div;
      logic [31:0] exp_data;
      is_div   = (k == 0);
      exp_data = is_div ? 32'd5 : 32'd4;
      bus.dx_is_md  = 1'b1;
      bus.dx_is_div = is_div;
      bus.dx_rd     = 5'd7;
      tick(); #4;
      if ({bus.ctrl_div, bus.ctrl_mult} !== {is_div, ~is_div}) begin
        $display("FAIL exc%0d_issue: got div/mult %b%b want %b%b", k, bus.ctrl_div, bus.ctrl_mult, is_div, ~is_div); n_err++;
      end
      n_vec++;
      tick();
      bus.md_ready     = 1'b1;
      bus.md_exception = 1'b1;
      bus.md_result    = 32'hDEAD_BEEF;
      #4;
      if (bus.stall !== 1'b1) begin $display("FAIL exc%0d_busy_stall: got %b want 1", k, bus.stall); n_err++; end
      n_vec++;
      tick();
      bus.md_ready     = 1'b0;
      bus.md_exception = 1'b0;
      #4;
      if ({bus.wb_en, bus.wb_reg, bus.wb_data, bus.stall} !== {1'b1, 5'd30, exp_data, 1'b0}) begin
        $display("FAIL exc%0d_wb: got wen/reg/data/stall %b/%0d/%h/%b want 1/30/%h/0",
                 k, bus.wb_en, bus.wb_reg, bus.wb_data, bus.stall, exp_data); n_err++;
      end
      n_vec++;
      tick();
      bus.dx_is_md = 1'b0;
      tick();
    end
  endtask

  // MW holds the port for two cycles, then a back-to-back div follows the release
  task automatic test_mw_priority;
    bus.dx_is_md  = 1'b1;
    bus.dx_is_div = 1'b0;
    bus.dx_rd     = 5'd12;
    tick(); tick();
    bus.md_ready  = 1'b1;
    bus.md_result = 32'h0000_0099;
    tick();
    bus.md_ready = 1'b0;
    bus.mw_wen   = 1'b1;
    bus.mw_rd    = 5'd3;
    bus.mw_data  = 32'h0000_AAAA;
    for (int i = 0; i < 2; i++) begin
      #4;
      if ({bus.wb_en, bus.wb_reg, bus.wb_data, bus.stall} !== {1'b1, 5'd3, 32'h0000_AAAA, 1'b1}) begin
        $display("FAIL mw_hold%0d: got wen/reg/data/stall %b/%0d/%h/%b want 1/3/0000aaaa/1",
                 i, bus.wb_en, bus.wb_reg, bus.wb_data, bus.stall); n_err++;
      end
      n_vec++;
      tick();
    end
    bus.mw_wen = 1'b0;
    #4;
    if ({bus.wb_en, bus.wb_reg, bus.wb_data, bus.stall} !== {1'b1, 5'd12, 32'h0000_0099, 1'b0}) begin
      $display("FAIL mw_md_write: got wen/reg/data/stall %b/%0d/%h/%b want 1/12/00000099/0",
               bus.wb_en, bus.wb_reg, bus.wb_data, bus.stall); n_err++;
    end
    n_vec++;
    tick();
    bus.dx_is_div = 1'b1;
    bus.dx_rd     = 5'd9;
    tick(); #4;
    if ({bus.ctrl_div, bus.ctrl_mult} !== 2'b10) begin
      $display("FAIL b2b_issue: got div/mult %b%b want 10", bus.ctrl_div, bus.ctrl_mult); n_err++;
    end
    n_vec++;
    tick();
    bus.md_ready  = 1'b1;
    bus.md_result = 32'h0000_0003;
    tick();
    bus.md_ready = 1'b0;
    #4;
    if ({bus.wb_en, bus.wb_reg, bus.wb_data} !== {1'b1, 5'd9, 32'h3}) begin
      $display("FAIL b2b_wb: got wen/reg/data %b/%0d/%h want 1/9/00000003", bus.wb_en, bus.wb_reg, bus.wb_data); n_err++;
    end
    n_vec++;
    tick();
    quiet_inputs();
    tick();
  endtask

  // Counter runs 0..TIMEOUT in BUSY, so 41 BUSY cycles precede the forced WB
  task automatic test_timeout;
    for (int k = 0; k < 2; k++) begin
      int          n;
      logic        is_div;
      logic [31:0] exp_data;
      is_div   = (k == 0);
      exp_data = is_div ? 32'd5 : 32'd4;
      bus.dx_is_md  = 1'b1;
      bus.dx_is_div = is_div;
      bus.dx_rd     = 5'd4;
      tick(); tick();
      n = 0;
      #4;
      while (bus.wb_en !== 1'b1 && n < 100) begin
        if (bus.stall !== 1'b1) begin $display("FAIL tmo%0d_stall: got %b want 1 at busy %0d", k, bus.stall, n); n_err++; end
        n_vec++;
        tick(); #4;
        n++;
      end
      if (n !== 41) begin $display("FAIL tmo%0d_cycles: got %0d want 41", k, n); n_err++; end
      n_vec++;
      if ({bus.wb_reg, bus.wb_data, bus.stall} !== {5'd30, exp_data, 1'b0}) begin
        $display("FAIL tmo%0d_wb: got reg/data/stall %0d/%h/%b want 30/%h/0", k, bus.wb_reg, bus.wb_data, bus.stall, exp_data); n_err++;
      end
      n_vec++;
      tick();
      bus.dx_is_md = 1'b0;
      tick();
    end
  endtask

  task automatic test_rd_zero;
    bus.dx_is_md  = 1'b1;
    bus.dx_is_div = 1'b0;
    bus.dx_rd     = 5'd0;
    tick(); tick();
    bus.md_ready  = 1'b1;
    bus.md_result = 32'h0000_0077;
    tick();
    bus.md_ready = 1'b0;
    #4;
    if ({bus.wb_en, bus.stall, bus.bubble} !== 3'b001) begin
      $display("FAIL rd0_wb: got wen/stall/bubble %b want 001", {bus.wb_en, bus.stall, bus.bubble}); n_err++;
    end
    n_vec++;
    tick();
    bus.dx_is_md = 1'b0;
    #4;
    if ({bus.wb_en, bus.stall, bus.bubble} !== 3'b000) begin
      $display("FAIL rd0_release: got wen/stall/bubble %b want 000", {bus.wb_en, bus.stall, bus.bubble}); n_err++;
    end
    n_vec++;
    tick();
  endtask

  task automatic test_reset_mid;
    int writes;
    bus.dx_is_md  = 1'b1;
    bus.dx_is_div = 1'b1;
    bus.dx_rd     = 5'd11;
    tick(); tick(); tick();
    reset        = 1'b0;
    bus.dx_is_md = 1'b0;
    #1;
    if ({bus.stall, bus.bubble, bus.ctrl_div} !== 3'b000) begin
      $display("FAIL rstmid_async: got stall/bubble/div %b want 000", {bus.stall, bus.bubble, bus.ctrl_div}); n_err++;
    end
    n_vec++;
    tick();
    reset         = 1'b1;
    bus.md_ready  = 1'b1;
    bus.md_result = 32'h0000_0055;
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      #4;
      if (bus.wb_en === 1'b1 || bus.stall === 1'b1 || bus.ctrl_div === 1'b1) writes++;
      tick();
      bus.md_ready = 1'b0;
    end
    if (writes !== 0) begin $display("FAIL rstmid_no_write: got %0d active cycles want 0", writes); n_err++; end
    n_vec++;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_mult_basic();
    test_exception();
    test_mw_priority();
    test_timeout();
    test_rd_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
